// File: rtl/vmc_pkg.sv
// Shared definitions for the vending machine coin front-end: denomination indices, rupee values, channel states.
package vmc_pkg;

  localparam int NUM_COINS = 4;

  localparam int COIN_1RS  = 0;
  localparam int COIN_2RS  = 1;
  localparam int COIN_5RS  = 2;
  localparam int COIN_10RS = 3;

  // Indexed by coin channel: [0]=1, [1]=2, [2]=5, [3]=10.
  localparam logic [NUM_COINS-1:0][3:0] COIN_VALUE = {4'd10, 4'd5, 4'd2, 4'd1};

  typedef enum logic [2:0] {
    REARM,
    IDLE,
    DEB_ON,
    ACTIVE,
    DEB_OFF,
    JAM
  } chan_state_t;

endpackage

// File: rtl/coin_debounce_channel.sv
// One coin sensor: 2-flop synchroniser, debounce/jam FSM; qualify is a combinational 1-cycle strobe
// raised DEBOUNCE_CYCLES+1 edges after the synchronised level rises; no backpressure (level input).
module coin_debounce_channel
  import vmc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic qualify,
  output logic jam
);

  localparam int CW = $clog2(JAM_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] JAM_MAX = CW'(JAM_CYCLES);

  logic [1:0]    sync_q;
  logic          s;
  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b00;
      state_q <= REARM;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s       = sync_q[1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qualify = 1'b0;
    case (state_q)
      REARM: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (s) begin
          state_d = DEB_ON;
          cnt_d   = CW'(1);
        end
      end
      DEB_ON: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          qualify = 1'b1;
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACTIVE: begin
        if (!s) begin
          state_d = DEB_OFF;
          cnt_d   = CW'(1);
        end else if (cnt_q == JAM_MAX) begin
          state_d = JAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DEB_OFF: begin
        // A high here is release bounce: return to ACTIVE without a new coin.
        if (s) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      JAM: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = REARM;
        cnt_d   = '0;
      end
    endcase
  end

  assign jam = (state_q == JAM);

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces four coin sensors and arbitrates them into one registered coin event; valid 1 cycle after
// edge DEBOUNCE_CYCLES+2 of a steady raw high; no backpressure, accept_en=0 turns a coin into a reject. Option: COIN_TALLY_EN.
module coin_input_conditioner
  import vmc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  coin_raw,
  input  logic        accept_en,
  output logic [3:0]  coin_pulse,
  output logic [3:0]  coin_value,
  output logic        coin_valid,
  output logic        coin_reject,
  output logic [3:0]  jam
`ifdef COIN_TALLY_EN
  ,
  output logic [31:0] tally,
  output logic [7:0]  reject_count
`endif
);

  logic [3:0] qual;
  logic [3:0] jam_w;
  logic       single;
  logic       fwd;
  logic [3:0] val;

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_chan
    coin_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .JAM_CYCLES     (JAM_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .raw    (coin_raw[i]),
      .qualify(qual[i]),
      .jam    (jam_w[i])
    );
  end

  always_comb begin
    single = (qual != 4'd0) && ((qual & (qual - 4'd1)) == 4'd0);
    fwd    = single && accept_en;
    val    = 4'd0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (qual[i]) val = COIN_VALUE[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_pulse  <= 4'd0;
      coin_value  <= 4'd0;
      coin_valid  <= 1'b0;
      coin_reject <= 1'b0;
      jam         <= 4'd0;
    end else begin
      coin_pulse  <= fwd ? qual : 4'd0;
      coin_value  <= fwd ? val : 4'd0;
      coin_valid  <= fwd;
      coin_reject <= (|qual) && !fwd;
      jam         <= jam_w;
    end
  end

`ifdef COIN_TALLY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tally        <= 32'd0;
      reject_count <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (coin_pulse[i] && (tally[8*i +: 8] != 8'hFF)) tally[8*i +: 8] <= tally[8*i +: 8] + 8'd1;
      end
      if (coin_reject && (reject_count != 8'hFF)) reject_count <= reject_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner: latency, bounce, arbitration, accept gating, jam, reset-held coin.
module tb_coin_input_conditioner;

  localparam int DEB = 4;
  localparam int JAMC = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  coin_raw;
  logic        accept_en;
  logic [3:0]  coin_pulse;
  logic [3:0]  coin_value;
  logic        coin_valid;
  logic        coin_reject;
  logic [3:0]  jam;
`ifdef COIN_TALLY_EN
  logic [31:0] tally;
  logic [7:0]  reject_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  int nv, nr, fv, lv, bad;
  logic [3:0] po, vo, jo;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .JAM_CYCLES(JAMC)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_raw   (coin_raw),
    .accept_en  (accept_en),
    .coin_pulse (coin_pulse),
    .coin_value (coin_value),
    .coin_valid (coin_valid),
    .coin_reject(coin_reject),
    .jam        (jam)
`ifdef COIN_TALLY_EN
    ,
    .tally       (tally),
    .reject_count(reject_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges (edge 0 is the first one after the call) and summarises what the outputs did.
  task automatic observe(input int n, output int o_nv, output int o_nr, output int o_fv, output int o_lv,
                         output logic [3:0] o_po, output logic [3:0] o_vo, output logic [3:0] o_jo, output int o_bad);
    o_nv = 0; o_nr = 0; o_fv = -1; o_lv = -1; o_po = 4'd0; o_vo = 4'd0; o_jo = 4'd0; o_bad = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (coin_valid) begin
        o_nv++;
        if (o_fv < 0) o_fv = k;
        o_lv = k;
        o_po |= coin_pulse;
        o_vo |= coin_value;
      end
      if (coin_reject) o_nr++;
      o_jo |= jam;
      if ((!coin_valid && coin_value != 4'd0) || (coin_valid != (|coin_pulse))) o_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; coin_raw = 4'd0; accept_en = 1'b1;
    tick(); tick();
    n_cmp++; if (coin_pulse !== 4'd0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0000", coin_pulse); end
    n_cmp++; if (coin_value !== 4'd0) begin n_fail++; $display("FAIL reset_value: got %0d want 0", coin_value); end
    n_cmp++; if (coin_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", coin_valid); end
    n_cmp++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %b want 0", coin_reject); end
    n_cmp++; if (jam !== 4'd0) begin n_fail++; $display("FAIL reset_jam: got %b want 0000", jam); end
    rst = 1'b1;
    observe(10, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 0 || nr !== 0) begin n_fail++; $display("FAIL reset_idle: got valid=%0d reject=%0d want 0/0", nv, nr); end
  endtask

  task automatic test_latency();
    coin_raw = 4'b0010;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL lat_count: got %0d want 1", nv); end
    n_cmp++; if (fv !== DEB + 2) begin n_fail++; $display("FAIL lat_edge: got %0d want %0d", fv, DEB + 2); end
    n_cmp++; if (po !== 4'b0010) begin n_fail++; $display("FAIL lat_pulse: got %b want 0010", po); end
    n_cmp++; if (vo !== 4'd2) begin n_fail++; $display("FAIL lat_value: got %0d want 2", vo); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL lat_consistency: got %0d bad cycles want 0", bad); end
    coin_raw = 4'd0;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 0 || nr !== 0) begin n_fail++; $display("FAIL lat_release: got valid=%0d reject=%0d want 0/0", nv, nr); end
  endtask

  task automatic test_bounce();
    logic [4:0] seq;
    int bounce_nv;
    seq = 5'b01101;
    bounce_nv = 0;
    for (int k = 0; k < 5; k++) begin
      coin_raw = {1'b0, seq[k], 2'b00};
      observe(1, nv, nr, fv, lv, po, vo, jo, bad);
      bounce_nv += nv + nr;
    end
    coin_raw = 4'b0100;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (bounce_nv !== 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d events want 0", bounce_nv); end
    n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL bounce_count: got %0d want 1", nv); end
    n_cmp++; if (fv !== DEB + 2) begin n_fail++; $display("FAIL bounce_edge: got %0d want %0d", fv, DEB + 2); end
    n_cmp++; if (vo !== 4'd5) begin n_fail++; $display("FAIL bounce_value: got %0d want 5", vo); end
    coin_raw = 4'd0;
    observe(15, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL bounce_release: got %0d want 0", nv); end
  endtask

  task automatic test_simultaneous();
    coin_raw = 4'b1001;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nr !== 1) begin n_fail++; $display("FAIL simul_reject: got %0d want 1", nr); end
    n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL simul_valid: got %0d want 0", nv); end
    n_cmp++; if (jo !== 4'd0) begin n_fail++; $display("FAIL simul_jam: got %b want 0000", jo); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL simul_value: got %0d bad cycles want 0", bad); end
    coin_raw = 4'd0;
    observe(15, nv, nr, fv, lv, po, vo, jo, bad);
  endtask

  task automatic test_accept_disabled();
    accept_en = 1'b0;
    coin_raw = 4'b1000;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nr !== 1 || nv !== 0) begin n_fail++; $display("FAIL noacc_reject: got reject=%0d valid=%0d want 1/0", nr, nv); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL noacc_value: got %0d nonzero-value cycles want 0", bad); end
    coin_raw = 4'd0;
    observe(15, nv, nr, fv, lv, po, vo, jo, bad);
    accept_en = 1'b1;
    coin_raw = 4'b1000;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 1 || vo !== 4'd10) begin n_fail++; $display("FAIL noacc_after: got valid=%0d value=%0d want 1/10", nv, vo); end
    n_cmp++; if (po !== 4'b1000) begin n_fail++; $display("FAIL noacc_pulse: got %b want 1000", po); end
    coin_raw = 4'd0;
    observe(15, nv, nr, fv, lv, po, vo, jo, bad);
  endtask

  task automatic test_back_to_back();
    coin_raw = 4'b0001;
    tick();
    coin_raw = 4'b0011;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    // 1Rs started one edge earlier, so it lands at index DEB+1 of this window and 2Rs at DEB+2.
    n_cmp++; if (nv !== 2 || nr !== 0) begin n_fail++; $display("FAIL b2b_count: got valid=%0d reject=%0d want 2/0", nv, nr); end
    n_cmp++; if (fv !== DEB + 1 || lv !== DEB + 2) begin n_fail++; $display("FAIL b2b_edges: got %0d,%0d want %0d,%0d", fv, lv, DEB + 1, DEB + 2); end
    n_cmp++; if (po !== 4'b0011) begin n_fail++; $display("FAIL b2b_pulse: got %b want 0011", po); end
    coin_raw = 4'd0;
    observe(15, nv, nr, fv, lv, po, vo, jo, bad);
  endtask

  task automatic test_jam();
    coin_raw = 4'b0001;
    observe(JAMC + 10, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL jam_single: got %0d want 1", nv); end
    n_cmp++; if (jam !== 4'b0001) begin n_fail++; $display("FAIL jam_set: got %b want 0001", jam); end
    coin_raw = 4'd0;
    observe(10, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (jam !== 4'd0) begin n_fail++; $display("FAIL jam_clear: got %b want 0000", jam); end
    n_cmp++; if (nv !== 0 || nr !== 0) begin n_fail++; $display("FAIL jam_release: got valid=%0d reject=%0d want 0/0", nv, nr); end
  endtask

  task automatic test_reset_held_coin();
    coin_raw = 4'b0010;
    observe(3, nv, nr, fv, lv, po, vo, jo, bad);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 0 || nr !== 0) begin n_fail++; $display("FAIL held_noevent: got valid=%0d reject=%0d want 0/0", nv, nr); end
    coin_raw = 4'd0;
    observe(10, nv, nr, fv, lv, po, vo, jo, bad);
    coin_raw = 4'b0010;
    observe(20, nv, nr, fv, lv, po, vo, jo, bad);
    n_cmp++; if (nv !== 1 || fv !== DEB + 2) begin n_fail++; $display("FAIL held_reinsert: got valid=%0d edge=%0d want 1/%0d", nv, fv, DEB + 2); end
`ifdef COIN_TALLY_EN
    n_cmp++; if (tally !== 32'h0000_0100) begin n_fail++; $display("FAIL tally: got %h want 00000100", tally); end
    n_cmp++; if (reject_count !== 8'd0) begin n_fail++; $display("FAIL reject_count: got %0d want 0", reject_count); end
`endif
    coin_raw = 4'd0;
    observe(10, nv, nr, fv, lv, po, vo, jo, bad);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_simultaneous();
    test_accept_disabled();
    test_back_to_back();
    test_jam();
    test_reset_held_coin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
Upstream front-end of the vending machine controller. Synchronises and debounces the four raw coin-sensor lines (1, 2, 5, 10 Rs), detects jams, arbitrates simultaneous insertions, and emits exactly one clean single-cycle event per physical coin. The vending machine controller consumes coin_pulse and coin_value directly, with no stretching or counting of its own.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles at a level before the level is accepted (min 2).
JAM_CYCLES, 1000, cycles a coin may stay asserted after qualification before the channel is declared jammed (> DEBOUNCE_CYCLES).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
coin_raw  in  4  raw sensor lines; bit0 = 1Rs, bit1 = 2Rs, bit2 = 5Rs, bit3 = 10Rs; asynchronous to clk.
accept_en  in  1  downstream able to take coins; sampled in the qualification cycle.
coin_pulse  out  4  one-hot, 1-cycle pulse of the accepted denomination.
coin_value  out  4  rupee value of the accepted coin (1/2/5/10); 0 when coin_valid = 0.
coin_valid  out  1  1-cycle strobe, equals OR of coin_pulse.
coin_reject  out  1  1-cycle strobe; coin qualified but not forwarded.
jam  out  4  level, per-channel jam flag.

Behaviour:
- Reset (rst = 0, async): all outputs 0; synchroniser flops 0; counters 0; every channel enters REARM.
- Synchroniser: 2 flops per bit; s[i] is the second flop.
- Per-channel FSM, with counter cnt (width clog2(JAM_CYCLES+1)):
  - REARM: wait for s low for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE. A coin held through reset is never counted.
  - IDLE: s = 1 -> DEB_ON, cnt = 1.
  - DEB_ON: s = 0 (bounce) -> IDLE, cnt = 0. When cnt reaches DEBOUNCE_CYCLES with s = 1, the channel qualifies and moves to ACTIVE with cnt = 0.
  - ACTIVE: s = 0 -> DEB_OFF. cnt reaching JAM_CYCLES -> JAM.
  - DEB_OFF: s = 1 -> ACTIVE; this is release bounce and must not produce a new coin. DEBOUNCE_CYCLES consecutive lows -> IDLE.
  - JAM: jam[i] = 1; same release rule as DEB_OFF, exiting to IDLE and clearing jam[i]. A jammed channel never qualifies.
- Latency: with raw high from edge 0 and held, coin_valid is high for exactly the one cycle after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- Arbitration, evaluated on the qualification cycle (outputs registered):
  - Exactly one channel qualifies and accept_en = 1: coin_pulse[i] = 1, coin_value = value(i), coin_valid = 1.
  - Exactly one channel qualifies and accept_en = 0: coin_reject = 1 only.
  - Two or more channels qualify in the same cycle: coin_reject = 1 and nothing is forwarded. All qualifying channels still go to ACTIVE.
- Never more than one coin_valid per physical coin. Back-to-back coins on different channels in consecutive cycles produce consecutive pulses.
- Counters saturate and never wrap.

Optional Feature:
COIN_TALLY_EN
- Defined: adds output tally (4 x 8-bit, packed 32-bit port) of accepted coins per denomination. Each count increments on coin_pulse[i], saturates at 255, and is cleared by reset. Also adds output reject_count (8-bit, saturating).
- Undefined: neither port exists and there is no added logic.

Decomposition:
- Package vmc_pkg holds:
  - coin index constants COIN_1RS..COIN_10RS;
  - COIN_VALUE constant array {1,2,5,10};
  - channel state enum {REARM, IDLE, DEB_ON, ACTIVE, DEB_OFF, JAM}.
- Sub-module coin_debounce_channel holds the synchroniser, FSM and counter for one channel; it outputs qualify (1-cycle) and jam. It is instantiated 4x.
- The top level holds arbitration, output registers and the optional tallies.

Test Plan:
- Reset release with coin_raw = 0 for 10 cycles, then 2Rs held 20 cycles -> coin_pulse = 4'b0010, coin_value = 2, coin_valid for 1 cycle after edge 6; nothing further on release.
- 5Rs raw toggles 1,0,1,1,0 (bounce) then steady high -> no pulse during bounce; exactly one pulse, DEBOUNCE_CYCLES+2 edges after the last rising sample.
- 1Rs and 10Rs rise on the same edge, both held -> coin_reject = 1 for one cycle, coin_valid stays 0, jam = 0.
- accept_en = 0 while a 10Rs coin qualifies -> coin_reject pulse, coin_value = 0; after the coin is released and accept_en = 1, a new 10Rs coin -> coin_value = 10.
- 1Rs held for JAM_CYCLES + 10 cycles -> single coin_valid, then jam[0] = 1; after release for 4 cycles jam[0] = 0, with no extra pulse.
- 2Rs held, rst pulsed low mid-hold, coin still held after reset -> no pulse. Release for 4 cycles, reinsert -> one pulse. With COIN_TALLY_EN defined, tally[2Rs] = 1.
